// File: rtl/sd_pkg.sv
// Shared SD-controller definitions: block geometry, SDC register map,
// MMC command/response codes and the block-sink unpacker state type.
package sd_pkg;

    localparam int SD_BLOCK_BYTES = 512;

    // SDC register byte offsets (controller slave port)
    localparam logic [7:0] SDC_ARGUMENT      = 8'h00;
    localparam logic [7:0] SDC_COMMAND       = 8'h04;
    localparam logic [7:0] SDC_STATUS        = 8'h08;
    localparam logic [7:0] SDC_RESP1         = 8'h0C;
    localparam logic [7:0] SDC_CONTROL       = 8'h1C;
    localparam logic [7:0] SDC_TIMEOUT       = 8'h20;
    localparam logic [7:0] SDC_CLOCK_DIV     = 8'h24;
    localparam logic [7:0] SDC_SOFT_RESET    = 8'h28;
    localparam logic [7:0] SDC_BLOCK_SIZE    = 8'h44;
    localparam logic [7:0] SDC_BLOCK_COUNT   = 8'h48;
    localparam logic [7:0] SDC_DST_SRC_ADDR  = 8'h60;

    // MMC/SD command indices used by the SD bus master
    localparam logic [5:0] MMC_GO_IDLE_STATE       = 6'd0;
    localparam logic [5:0] MMC_SEND_IF_COND        = 6'd8;
    localparam logic [5:0] MMC_SET_BLOCKLEN        = 6'd16;
    localparam logic [5:0] MMC_READ_SINGLE_BLOCK   = 6'd17;
    localparam logic [5:0] MMC_READ_MULTIPLE_BLOCK = 6'd18;
    localparam logic [5:0] SD_APP_OP_COND          = 6'd41;
    localparam logic [5:0] MMC_APP_CMD             = 6'd55;

    // Response length codes
    localparam logic [1:0] MMC_RSP_NONE = 2'd0;
    localparam logic [1:0] MMC_RSP_48   = 2'd1;
    localparam logic [1:0] MMC_RSP_136  = 2'd2;

    localparam logic [3:0] WB_SEL_ALL = 4'b1111;

    // Unpacker: EMPTY, or holding a word with the next byte index 0..3
    typedef enum logic [2:0] {
        UNPACK_EMPTY = 3'd0,
        UNPACK_B0    = 3'd1,
        UNPACK_B1    = 3'd2,
        UNPACK_B2    = 3'd3,
        UNPACK_B3    = 3'd4
    } unpack_state_e;

    // Big-endian byte pick: index 0 is the most significant byte
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data; pop loads pop_data on the edge.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 128
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Push is gated on the registered full flag only, so a pop at full never frees a slot for the same edge
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full & ~clear;
    assign do_pop  = pop & ~empty & ~clear;

    // Storage array write
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pop_data <= '0;
        end else if (do_pop) begin
            pop_data <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/sd_block_sink.sv
// Wishbone write sink for SD DMA words: buffers 32-bit words and emits a
// big-endian byte stream with a last-of-block marker.
//
// Byte stream handshake: a byte transfers on a clock edge where byte_valid
// and byte_ready are both high; while byte_valid is high and byte_ready low,
// byte_data, byte_valid and byte_last hold their values.
module sd_block_sink
    import sd_pkg::*;
#(
    parameter int FIFO_DEPTH  = 128,
    parameter int BLOCK_BYTES = SD_BLOCK_BYTES
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          flush,
    input  logic [31:0]                   wbs_adr_i,
    input  logic [31:0]                   wbs_dat_i,
    input  logic [3:0]                    wbs_sel_i,
    input  logic                          wbs_we_i,
    input  logic                          wbs_cyc_i,
    input  logic                          wbs_stb_i,
    output logic                          wbs_ack_o,
    output logic [31:0]                   wbs_dat_o,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic                          byte_last,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          sel_error,
    output unpack_state_e                 dbg_state
);

    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = $clog2(BLOCK_BYTES);

    logic          req;
    logic          wr_req;
    logic          sel_ok;
    logic          occ_full;
    logic          push;
    logic          accept;
    logic          pop;
    logic          hs;
    logic          mem_full;
    logic          mem_empty;
    logic [LW-1:0] mem_level;
    logic [31:0]   word;
    logic [1:0]    byte_idx;
    logic [CW-1:0] byte_cnt;
    unpack_state_e state_q;
    unpack_state_e state_d;
    logic          unused_adr;

    assign unused_adr = ^wbs_adr_i;

    // A request is only live before its ack; the ack cycle itself is not re-sampled
    assign req    = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign wr_req = req & wbs_we_i;
    assign sel_ok = (wbs_sel_i == WB_SEL_ALL);

    // Occupancy counts the word held by the unpacker too, so the master sees FIFO_DEPTH words of room in total
    assign fifo_level = mem_level + LW'(byte_valid);
    assign occ_full   = (fifo_level == LW'(FIFO_DEPTH));

    assign push   = wr_req & sel_ok & ~flush & ~occ_full & ~mem_full;
    assign accept = req & ~flush & (~wbs_we_i | ~sel_ok | ~(occ_full | mem_full));

    assign wbs_dat_o = '0;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (flush),
        .push      (push),
        .push_data (wbs_dat_i),
        .pop       (pop),
        .pop_data  (word),
        .full      (mem_full),
        .empty     (mem_empty),
        .level     (mem_level)
    );

    // Registered single-cycle acknowledge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wbs_ack_o <= 1'b0;
        end else begin
            wbs_ack_o <= accept;
        end
    end

    // Sticky partial-select error, cleared only by flush or reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sel_error <= 1'b0;
        end else if (flush) begin
            sel_error <= 1'b0;
        end else if (wr_req & ~sel_ok) begin
            sel_error <= 1'b1;
        end
    end

    assign byte_valid = (state_q != UNPACK_EMPTY);
    assign hs         = byte_valid & byte_ready;
    assign dbg_state  = state_q;

    // Unpacker state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= UNPACK_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Unpacker next state; the last byte of a word pops the next one in the same cycle
    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        byte_idx = 2'd0;
        case (state_q)
            UNPACK_EMPTY: begin
                if (!mem_empty) begin
                    pop     = 1'b1;
                    state_d = UNPACK_B0;
                end
            end
            UNPACK_B0: begin
                byte_idx = 2'd0;
                if (hs) state_d = UNPACK_B1;
            end
            UNPACK_B1: begin
                byte_idx = 2'd1;
                if (hs) state_d = UNPACK_B2;
            end
            UNPACK_B2: begin
                byte_idx = 2'd2;
                if (hs) state_d = UNPACK_B3;
            end
            UNPACK_B3: begin
                byte_idx = 2'd3;
                if (hs) begin
                    if (!mem_empty) begin
                        pop     = 1'b1;
                        state_d = UNPACK_B0;
                    end else begin
                        state_d = UNPACK_EMPTY;
                    end
                end
            end
            default: state_d = UNPACK_EMPTY;
        endcase
        if (flush) begin
            state_d = UNPACK_EMPTY;
            pop     = 1'b0;
        end
    end

    assign byte_data = byte_valid ? word_byte(word, byte_idx) : 8'h00;

    // Position of the current byte within its block
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
        end else if (flush) begin
            byte_cnt <= '0;
        end else if (hs) begin
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

    assign byte_last = byte_valid & (byte_cnt == CW'(BLOCK_BYTES - 1));

endmodule

// File: tb/tb_sd_block_sink.sv
// Self-checking bench for sd_block_sink: byte-queue reference model,
// a table of single Wishbone transfers and hand-written corner sequences.
module tb_sd_block_sink;
  import sd_pkg::*;

  localparam int DEPTH = 128;
  localparam int BLOCK = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        flush;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_we_i;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic [$clog2(DEPTH):0] fifo_level;
  logic        sel_error;
  unpack_state_e dbg_state;

  sd_block_sink #(.FIFO_DEPTH(DEPTH), .BLOCK_BYTES(BLOCK)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .wbs_adr_i  (wbs_adr_i),
    .wbs_dat_i  (wbs_dat_i),
    .wbs_sel_i  (wbs_sel_i),
    .wbs_we_i   (wbs_we_i),
    .wbs_cyc_i  (wbs_cyc_i),
    .wbs_stb_i  (wbs_stb_i),
    .wbs_ack_o  (wbs_ack_o),
    .wbs_dat_o  (wbs_dat_o),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .fifo_level (fifo_level),
    .sel_error  (sel_error),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_mis = 0;
  logic [7:0] exp_q[$];
  int blk_cnt = 0;
  int rdy_mode = 0;  // 0 low, 1 high, 2 random
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_q.push_back(w[31:24]);
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
  endtask

  task automatic model_clear();
    exp_q.delete();
    blk_cnt = 0;
  endtask

  // Consumer ready driver
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       byte_ready = 1'b0;
      1:       byte_ready = 1'b1;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Byte monitor: every handshake is compared with the model queue
  always @(negedge clk) begin
    logic [7:0] e;
    logic       el;
    if (reset_n && byte_valid && byte_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL stray_byte: got %0h expected no byte", byte_data);
      end else begin
        e  = exp_q.pop_front();
        el = ((blk_cnt % BLOCK) == BLOCK - 1);
        if (byte_data !== e || byte_last !== el) begin
          n_mis++;
          $display("FAIL stream_byte #%0d: got data %0h last %0b expected data %0h last %0b",
                   blk_cnt, byte_data, byte_last, e, el);
        end
      end
      blk_cnt++;
    end
    if (reset_n && prev_stall && byte_valid) begin
      n_vec++;
      if (byte_data !== prev_data) begin
        n_mis++;
        $display("FAIL stall_hold: got %0h expected %0h", byte_data, prev_data);
      end
    end
    prev_stall = byte_valid && !byte_ready;
    prev_data  = byte_data;
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic we, input logic [3:0] sel, input logic [31:0] dat,
                         input int budget, output int lat, output logic [31:0] rdat);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_sel_i = sel; wbs_dat_i = dat; wbs_adr_i = $urandom;
    lat  = -1;
    rdat = 32'hFFFF_FFFF;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        lat  = k;
        rdat = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (lat > 0 && we && sel == 4'b1111) push_word(dat);
  endtask

  task automatic write_word(input string name, input logic [31:0] dat);
    int lat;
    logic [31:0] rd;
    wb_xfer(1'b1, 4'b1111, dat, 8, lat, rd);
    check(name, lat, 1);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || byte_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, (exp_q.size() == 0 && !byte_valid), 1);
  endtask

  task automatic pulse_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_err;
  } wb_vec_t;

  wb_vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int start_cnt;
    logic [31:0] rd;
    logic seen;

    vecs[0] = '{we: 1'b1, sel: 4'b1111, dat: 32'h1122_3344, exp_err: 1'b0};
    vecs[1] = '{we: 1'b1, sel: 4'b0011, dat: 32'hCAFE_F00D, exp_err: 1'b1};
    vecs[2] = '{we: 1'b0, sel: 4'b1111, dat: 32'h5555_AAAA, exp_err: 1'b1};
    vecs[3] = '{we: 1'b1, sel: 4'b1111, dat: 32'hA1B2_C3D4, exp_err: 1'b1};
    vecs[4] = '{we: 1'b1, sel: 4'b1000, dat: 32'h0BAD_0BAD, exp_err: 1'b1};
    vecs[5] = '{we: 1'b0, sel: 4'b0000, dat: 32'h0000_0001, exp_err: 1'b1};

    reset_n = 1'b0; flush = 1'b0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
    wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    byte_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat_o", wbs_dat_o, 0);
    check("rst_byte_data", byte_data, 0);
    check("rst_byte_valid", byte_valid, 0);
    check("rst_byte_last", byte_last, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_sel_error", sel_error, 0);
    check("rst_state", dbg_state, UNPACK_EMPTY);
    @(negedge clk);
    reset_n = 1'b1;

    // One block of counting bytes, consumer always ready
    rdy_mode = 1;
    for (int i = 0; i < 128; i++) begin
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4 * i); b1 = 8'(4 * i + 1); b2 = 8'(4 * i + 2); b3 = 8'(4 * i + 3);
      write_word("t1_ack_lat", {b0, b1, b2, b3});
    end
    wait_drain("t1_drain", 300);
    check("t1_block_bytes", blk_cnt, 512);

    // Back-pressure: fill to capacity, 129th request must stall
    @(posedge clk);
    rdy_mode = 0;
    for (int i = 0; i < 128; i++) write_word("t2_ack_lat", $urandom);
    check("t2_level_full", fifo_level, 128);
    @(posedge clk); #1;
    rd = $urandom;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'b1111; wbs_dat_i = rd;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (wbs_ack_o) seen = 1'b1;
    end
    check("t2_full_no_ack", seen, 0);
    check("t2_level_hold", fifo_level, 128);
    @(posedge clk);
    rdy_mode = 1;
    repeat (4) @(posedge clk);
    rdy_mode = 0;
    lat = -1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (wbs_ack_o) begin
        lat = k;
        break;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    check("t2_ack_after_drain", (lat >= 1 && lat <= 2), 1);
    if (lat > 0) push_word(rd);
    check("t2_level_refill", fifo_level, 128);
    rdy_mode = 1;
    wait_drain("t2_drain", 700);

    // Table of single transfers: ack latency, read data, sticky select error
    pulse_flush();
    for (int v = 0; v < 6; v++) begin
      wb_xfer(vecs[v].we, vecs[v].sel, vecs[v].dat, 8, lat, rd);
      check($sformatf("tbl%0d_ack_lat", v), lat, 1);
      check($sformatf("tbl%0d_dat_o", v), rd, 0);
      wait_drain($sformatf("tbl%0d_drain", v), 50);
      check($sformatf("tbl%0d_sel_error", v), sel_error, vecs[v].exp_err);
      check($sformatf("tbl%0d_level", v), fifo_level, 0);
    end
    pulse_flush();
    check("flush_clears_sel_error", sel_error, 0);

    // Read while words are buffered leaves the level alone
    @(posedge clk);
    rdy_mode = 0;
    write_word("rd_fill_ack", $urandom);
    write_word("rd_fill_ack", $urandom);
    repeat (2) @(posedge clk);
    #1;
    check("rd_level_before", fifo_level, 2);
    wb_xfer(1'b0, 4'b1111, 32'h0, 8, lat, rd);
    check("rd_ack_lat", lat, 1);
    check("rd_dat_o", rd, 0);
    check("rd_level_after", fifo_level, 2);
    rdy_mode = 1;
    wait_drain("rd_drain", 50);

    // Flush racing a write request: flush wins, request accepted afterwards
    @(posedge clk);
    rdy_mode = 0;
    write_word("fl_fill_ack", $urandom);
    write_word("fl_fill_ack", $urandom);
    @(posedge clk); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'b1111;
    wbs_dat_i = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
    check("fl_no_ack", wbs_ack_o, 0);
    check("fl_level_zero", fifo_level, 0);
    check("fl_valid_zero", byte_valid, 0);
    @(posedge clk); #1;
    check("fl_ack_next", wbs_ack_o, 1);
    check("fl_latency_not_yet", byte_valid, 0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    if (wbs_ack_o) push_word(32'hDEAD_BEEF);
    rdy_mode = 1;
    @(posedge clk); #1;
    check("fl_latency_valid", byte_valid, 1);
    check("fl_first_byte", byte_data, 8'hDE);
    for (int i = 0; i < 127; i++) write_word("fl_blk_ack", $urandom);
    wait_drain("fl_drain", 300);
    check("fl_block_bytes", blk_cnt, 512);

    // Reset in the middle of a block
    wb_xfer(1'b1, 4'b0001, 32'h1234_5678, 8, lat, rd);
    check("rs_bad_sel_ack", lat, 1);
    check("rs_sel_error_set", sel_error, 1);
    @(posedge clk);
    rdy_mode = 0;
    for (int i = 0; i < 60; i++) write_word("rs_fill_ack", $urandom);
    start_cnt = blk_cnt;
    @(posedge clk);
    rdy_mode = 1;
    repeat (200) @(posedge clk);
    #2;
    check("rs_drain_rate", blk_cnt - start_cnt, 200);
    reset_n = 1'b0;
    #1;
    check("rs_ack", wbs_ack_o, 0);
    check("rs_dat_o", wbs_dat_o, 0);
    check("rs_byte_data", byte_data, 0);
    check("rs_byte_valid", byte_valid, 0);
    check("rs_byte_last", byte_last, 0);
    check("rs_fifo_level", fifo_level, 0);
    check("rs_sel_error", sel_error, 0);
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;

    // Next block after reset with a random consumer
    rdy_mode = 2;
    for (int i = 0; i < 128; i++) write_word("rs_blk_ack", $urandom);
    wait_drain("rs_drain", 3000);
    check("rs_block_bytes", blk_cnt, 512);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  // Global bound on run time
  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
